// File: rtl/period_meter_pkg.sv
// Shared types and helpers for the multi-channel period meter.
package period_meter_pkg;

  localparam int unsigned MAX_W = 32;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALE = 2'd2
  } chan_state_e;

  typedef struct packed {
    logic valid;
    logic stale;
    logic armed;
  } chan_flags_t;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v,
                                               input logic [MAX_W-1:0] lim);
    return (v >= lim) ? lim : v + MAX_W'(1);
  endfunction

endpackage

// File: rtl/period_meter_mc_chan.sv
// One measurement channel: synchronizer, edge detect, tick timer, FSM and output registers.
module period_chan
  import period_meter_pkg::*;
#(
  parameter int unsigned W         = 16,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned EDGE_MODE = EDGE_RISE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce_i,
  input  logic         sig_i,
  output logic [W-1:0] period_o,
  output chan_flags_t  flags_o
);

  localparam logic [W-1:0] CNT_MAX   = '1;
  localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);

  logic        sync1_q, sync2_q, dly_q, edge_q;
  logic        edge_c;

  chan_state_e state_q, state_d;
  logic [W-1:0] t_q, t_d;
  logic [W-1:0] period_q, period_d;
  logic        valid_q, valid_d;
  logic        stale_q, stale_d;
  logic        armed_q, armed_d;
  logic [W-1:0] t_inc_c;
  logic [W-1:0] measured_c;

  // Edge qualification on the synchronized input.
  always_comb begin
    edge_c = 1'b0;
    if (EDGE_MODE == EDGE_RISE) begin
      edge_c = sync2_q & ~dly_q;
    end else if (EDGE_MODE == EDGE_FALL) begin
      edge_c = ~sync2_q & dly_q;
    end else begin
      edge_c = sync2_q ^ dly_q;
    end
  end

  // Input pipeline: two sync stages, delay stage, registered edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      edge_q  <= edge_c;
    end
  end

  // A tick coinciding with the edge closes the current period.
  always_comb begin
    t_inc_c    = W'(sat_inc(MAX_W'(t_q), MAX_W'(CNT_MAX)));
    measured_c = ce_i ? t_inc_c : t_q;
  end

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    period_d = period_q;
    valid_d  = 1'b0;
    stale_d  = stale_q;
    armed_d  = armed_q;
    case (state_q)
      ST_IDLE: begin
        if (edge_q) begin
          state_d = ST_RUN;
          armed_d = 1'b1;
          t_d     = '0;
        end
      end
      ST_RUN: begin
        if (edge_q) begin
          period_d = measured_c;
          valid_d  = 1'b1;
          t_d      = '0;
        end else if (ce_i) begin
          t_d = t_inc_c;
          if (t_inc_c >= TIMEOUT_W) begin
            state_d  = ST_STALE;
            stale_d  = 1'b1;
            period_d = '0;
            armed_d  = 1'b0;
            t_d      = '0;
          end
        end
      end
      ST_STALE: begin
        // Timer is parked at zero; the re-arming edge starts a fresh interval.
        if (edge_q) begin
          state_d = ST_RUN;
          stale_d = 1'b0;
          armed_d = 1'b1;
          t_d     = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      t_q      <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stale_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stale_q  <= stale_d;
      armed_q  <= armed_d;
    end
  end

  assign period_o = period_q;
  assign flags_o  = '{valid: valid_q, stale: stale_q, armed: armed_q};

endmodule

// File: rtl/period_meter_mc.sv
// Multi-channel period meter: CH independent channels sharing clk, rst and the ce timebase.
module period_meter_mc
  import period_meter_pkg::*;
#(
  parameter int unsigned CH        = 4,
  parameter int unsigned W         = 16,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned EDGE_MODE = EDGE_RISE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [CH-1:0]   sig,
  output logic [CH*W-1:0] period,
  output logic [CH-1:0]   valid,
  output logic [CH-1:0]   stale,
  output logic [CH-1:0]   armed
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    chan_flags_t flags;

    period_chan #(
      .W        (W),
      .TIMEOUT  (TIMEOUT),
      .EDGE_MODE(EDGE_MODE)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .ce_i    (ce),
      .sig_i   (sig[i]),
      .period_o(period[i*W +: W]),
      .flags_o (flags)
    );

    assign valid[i] = flags.valid;
    assign stale[i] = flags.stale;
    assign armed[i] = flags.armed;
  end

endmodule

// File: tb/tb_period_meter_mc.sv
// Directed bench for period_meter_mc: three parameterizations driven from one ce timebase.
module tb_period_meter_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce;
  logic [3:0]  sig_a;
  logic [1:0]  sig_b;
  logic [0:0]  sig_c;

  logic [63:0] period_a;
  logic [3:0]  valid_a, stale_a, armed_a;
  logic [31:0] period_b;
  logic [1:0]  valid_b, stale_b, armed_b;
  logic [7:0]  period_c;
  logic [0:0]  valid_c, stale_c, armed_c;

  logic [3:0]  v3_a;
  logic [1:0]  v3_b;
  logic [0:0]  v3_c;

  int nvec = 0;
  int nerr = 0;

  period_meter_mc #(.CH(4), .W(16), .TIMEOUT(100), .EDGE_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .sig(sig_a),
    .period(period_a), .valid(valid_a), .stale(stale_a), .armed(armed_a)
  );

  period_meter_mc #(.CH(2), .W(16), .TIMEOUT(1000), .EDGE_MODE(2)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .sig(sig_b),
    .period(period_b), .valid(valid_b), .stale(stale_b), .armed(armed_b)
  );

  period_meter_mc #(.CH(1), .W(8), .TIMEOUT(255), .EDGE_MODE(0)) dut_c (
    .clk(clk), .rst(rst), .ce(ce), .sig(sig_c),
    .period(period_c), .valid(valid_c), .stale(stale_c), .armed(armed_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One timebase frame: ce high for the first of 10 clocks.
  task automatic frames(input int n);
    repeat (n) begin
      ce = 1'b1; adv(1);
      ce = 1'b0; adv(9);
    end
  endtask

  // First 4 clocks of a frame whose input change was applied at frame start.
  task automatic edge_frame();
    ce = 1'b1; adv(1);
    ce = 1'b0; adv(2);
    v3_a = valid_a; v3_b = valid_b; v3_c = valid_c;
    adv(1);
  endtask

  // Tick, then stop 3 clocks before the next tick so a change applied now lands with it.
  task automatic pre_coincide();
    ce = 1'b1; adv(1);
    ce = 1'b0; adv(6);
  endtask

  task automatic coincide_frame();
    adv(3);
    ce = 1'b1; adv(1);
    ce = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; sig_a = '0; sig_b = '0; sig_c = '0;
    adv(3);
    rst = 1'b0;
    chk("rst_period_a", period_a, 64'd0);
    chk("rst_valid_a", valid_a, 4'b0000);
    chk("rst_stale_a", stale_a, 4'b0000);
    chk("rst_armed_a", armed_a, 4'b0000);

    // Rising edges on ch0 every 50 ticks.
    sig_a[0] = 1'b1; edge_frame();
    chk("t1_arm_valid", valid_a, 4'b0000);
    chk("t1_arm_armed", armed_a, 4'b0001);
    adv(6); sig_a[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      frames(49);
      sig_a[0] = 1'b1; edge_frame();
      chk("t1_early", v3_a, 4'b0000);
      chk("t1_valid", valid_a, 4'b0001);
      chk("t1_period", period_a[15:0], 16'd50);
      adv(1);
      chk("t1_pulse_end", valid_a, 4'b0000);
      adv(5); sig_a[0] = 1'b0;
    end

    // ch2: edge lands with the 20th tick.
    sig_a[2] = 1'b1; edge_frame();
    adv(6); sig_a[2] = 1'b0;
    frames(18);
    pre_coincide();
    sig_a[2] = 1'b1;
    coincide_frame();
    chk("t3_valid", valid_a[2], 1'b1);
    chk("t3_period", period_a[47:32], 16'd20);
    adv(9); sig_a[2] = 1'b0;
    frames(9);
    sig_a[2] = 1'b1; edge_frame();
    chk("t3_next_period", period_a[47:32], 16'd10);
    adv(6); sig_a[2] = 1'b0;

    // ch3: measure, then let it time out at 100 ticks.
    sig_a[3] = 1'b1; edge_frame();
    adv(6); sig_a[3] = 1'b0;
    frames(29);
    sig_a[3] = 1'b1; edge_frame();
    chk("t4_period", period_a[63:48], 16'd30);
    adv(6); sig_a[3] = 1'b0;
    frames(99);
    chk("t4_pre_stale", stale_a[3], 1'b0);
    chk("t4_pre_armed", armed_a[3], 1'b1);
    ce = 1'b1; adv(1);
    chk("t4_stale", stale_a[3], 1'b1);
    chk("t4_stale_armed", armed_a[3], 1'b0);
    chk("t4_stale_period", period_a[63:48], 16'd0);
    chk("t4_stale_valid", valid_a[3], 1'b0);
    ce = 1'b0; adv(9);
    frames(5);
    sig_a[3] = 1'b1; edge_frame();
    chk("t4_rearm_stale", stale_a[3], 1'b0);
    chk("t4_rearm_armed", armed_a[3], 1'b1);
    chk("t4_rearm_valid", valid_a[3], 1'b0);
    chk("t4_rearm_period", period_a[63:48], 16'd0);
    adv(6); sig_a[3] = 1'b0;
    frames(39);
    sig_a[3] = 1'b1; edge_frame();
    chk("t4_valid", valid_a[3], 1'b1);
    chk("t4_period2", period_a[63:48], 16'd40);
    adv(6); sig_a[3] = 1'b0;

    // Both-edge mode: high 3 ticks, low 7 ticks.
    sig_b[1] = 1'b1; edge_frame();
    chk("t2_arm_valid", valid_b, 2'b00);
    chk("t2_arm_armed", armed_b, 2'b10);
    adv(6); frames(2);
    sig_b[1] = 1'b0; edge_frame();
    chk("t2_valid_hi", valid_b, 2'b10);
    chk("t2_period_hi", period_b[31:16], 16'd3);
    adv(6); frames(6);
    sig_b[1] = 1'b1; edge_frame();
    chk("t2_valid_lo", valid_b, 2'b10);
    chk("t2_period_lo", period_b[31:16], 16'd7);
    adv(6); frames(2);
    sig_b[1] = 1'b0; edge_frame();
    chk("t2_period_hi2", period_b[31:16], 16'd3);
    adv(6);

    // W=8, TIMEOUT=255: stale at 255, then a 255 measurement on a coincident edge.
    sig_c = 1'b1; edge_frame();
    chk("t5_arm", armed_c, 1'b1);
    adv(6); sig_c = 1'b0;
    frames(254);
    chk("t5_pre_stale", stale_c, 1'b0);
    ce = 1'b1; adv(1);
    chk("t5_stale", stale_c, 1'b1);
    chk("t5_stale_armed", armed_c, 1'b0);
    ce = 1'b0; adv(9);
    frames(44);
    sig_c = 1'b1; edge_frame();
    chk("t5_no300_valid", valid_c, 1'b0);
    chk("t5_no300_period", period_c, 8'd0);
    chk("t5_rearm_stale", stale_c, 1'b0);
    adv(6); sig_c = 1'b0;
    frames(253);
    pre_coincide();
    sig_c = 1'b1;
    coincide_frame();
    chk("t5_max_valid", valid_c, 1'b1);
    chk("t5_max_period", period_c, 8'd255);
    chk("t5_max_stale", stale_c, 1'b0);
    adv(9); sig_c = 1'b0;

    // All channels toggling, then reset in mid-frame.
    for (int f = 0; f < 30; f++) begin
      if (f % 3 == 0) sig_a[0] = ~sig_a[0];
      if (f % 5 == 0) sig_a[1] = ~sig_a[1];
      if (f % 7 == 0) sig_a[2] = ~sig_a[2];
      if (f % 4 == 0) sig_a[3] = ~sig_a[3];
      frames(1);
    end
    ce = 1'b1; adv(1);
    ce = 1'b0; adv(3);
    rst = 1'b1; sig_a = '0; sig_b = '0; sig_c = '0;
    adv(1);
    rst = 1'b0;
    chk("t6_rst_period_a", period_a, 64'd0);
    chk("t6_rst_valid_a", valid_a, 4'b0000);
    chk("t6_rst_stale_a", stale_a, 4'b0000);
    chk("t6_rst_armed_a", armed_a, 4'b0000);
    chk("t6_rst_period_b", period_b, 32'd0);
    chk("t6_rst_armed_b", armed_b, 2'b00);
    chk("t6_rst_period_c", period_c, 8'd0);
    adv(5);
    sig_a = 4'b0011; edge_frame();
    chk("t6_arm_valid", valid_a, 4'b0000);
    chk("t6_arm_armed", armed_a, 4'b0011);
    adv(6); sig_a = '0;
    frames(11);
    sig_a = 4'b0001; edge_frame();
    chk("t6_ch0_valid", valid_a, 4'b0001);
    chk("t6_ch0_period", period_a, {16'd0, 16'd0, 16'd0, 16'd12});
    adv(6); sig_a = '0;
    frames(7);
    sig_a = 4'b1010; edge_frame();
    chk("t6_ch1_early", v3_a, 4'b0000);
    chk("t6_ch1_valid", valid_a, 4'b0010);
    chk("t6_ch13_armed", armed_a, 4'b1011);
    chk("t6_ch1_period", period_a, {16'd0, 16'd0, 16'd20, 16'd12});
    adv(1);
    chk("t6_pulse_end", valid_a, 4'b0000);
    adv(5); sig_a = '0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
